hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32 pipeline.
- Drives the stall/flush inputs of the F/D/E/M/W pipeline registers and PC register from:
  - decode operand usage,
  - EX-stage load / branch / multi-cycle MDU status,
  - instruction and data memory wait handshakes.
- Small FSM sequences multi-cycle MDU ops and memory freezes; a pending-redirect flag squashes wrong-path fetches returning after a branch.

Parameters:
- REG_W, 5, register index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  REG_W  rs1 index of instruction in D
- id_rs2  in  REG_W  rs2 index of instruction in D
- id_use_rs1  in  1  D instruction reads rs1
- id_use_rs2  in  1  D instruction reads rs2
- ex_rd  in  REG_W  destination of instruction in E
- ex_is_load  in  1  E instruction is a load
- ex_branch_taken  in  1  E resolved taken branch/jump (PC redirect)
- ex_mdu_start  in  1  E holds a MUL/DIV op, first cycle
- mdu_done  in  1  MDU result valid; level, held until E advances
- imem_wait  in  1  instruction fetch not complete
- dmem_wait  in  1  data access in M not complete
- stall_fd  out  1  hold PC and D register
- flush_d  out  1  load zero into D register
- stall_e  out  1  hold E register
- flush_e  out  1  load bubble into E register
- flush_m  out  1  load bubble into M register
- stall_mw  out  1  hold M and W registers
- state_o  out  2  FSM state (debug)

Behaviour:
- All outputs combinational from state, redirect_pending and inputs; state and redirect_pending are registered.
- Reset: state=RUN (2'd0), redirect_pending=0; while rst=1 all stall/flush outputs 0.
- States:
  - RUN=0
  - MDU_WAIT=1
  - MEM_WAIT=2
  - 3 unused, decodes as RUN and transitions to RUN.
- MEM_WAIT is entered/held while (imem_wait|dmem_wait); freeze has top priority in any state:
  - stall_fd=stall_e=stall_mw=1, all flush=0.
  - On exit, returns to the state saved on entry (RUN or MDU_WAIT) via a 1-bit resume register.
  - With no wait asserted, evaluation is the same cycle the wait drops.
- RUN, no freeze, priority high to low:
  1. ex_branch_taken: flush_d=1, flush_e=1, no stalls; load-use and mdu_start ignored; if imem_wait also 1 this cycle, set redirect_pending.
  2. Load-use, when ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): stall_fd=1, flush_e=1.
  3. ex_mdu_start & !mdu_done: next state MDU_WAIT, with stall_fd=1, stall_e=1, flush_m=1 this cycle.
  4. else all 0.
- MDU_WAIT, no freeze:
  - mdu_done=0: stall_fd=1, stall_e=1, flush_m=1.
  - mdu_done=1: all 0 (E advances), next RUN.
  - Branch/load-use inputs are ignored; E holds the MDU op.
- redirect_pending: in the first cycle imem_wait=0, flush_d=1 (squash wrong-path fetch), then clear.
  - Combined with a RUN load-use: flush_d wins over stall_fd for D; the PC stall still applies.
- Single-cycle MDU (ex_mdu_start & mdu_done same cycle): stays RUN, no stall.
- rst mid-MDU_WAIT or mid-MEM_WAIT: RUN next cycle, pending cleared.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle stall_fd=1.
  - perf_flush_cnt increments each cycle flush_d=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → stall_fd=1, flush_e=1 for one cycle. Repeat with ex_rd=0 → all 0.
- Branch vs load-use: branch and load-use hazard in same cycle → flush_d=1, flush_e=1, stall_fd=0.
- MDU: ex_mdu_start=1, mdu_done low 3 cycles then high:
  - stall_fd/stall_e/flush_m=1 for 4 cycles (start + 3 wait), state_o=1;
  - cycle with mdu_done=1 → all 0, state_o=0 next.
- Freeze inside MDU: dmem_wait=1 for 2 cycles during MDU_WAIT → all stalls 1, flush_m=0, state_o=2; after drop, state_o=1 resumes.
- Redirect: ex_branch_taken=1 with imem_wait=1, imem_wait drops 2 cycles later → flush_d=1 exactly on first non-wait cycle, then 0.
- Reset mid-op: rst=1 during MDU_WAIT → next cycle state_o=0, all outputs 0. With HAZ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the 5-stage RV32 pipeline
//
// Purpose:
//   Generates the stall/flush controls for the F/D/E/M/W pipeline registers
//   and the PC register. The controls come from:
//     - operand usage in decode,
//     - load, branch and multi-cycle MDU status in execute,
//     - instruction and data memory wait handshakes.
//   A small FSM sequences multi-cycle MDU operations and memory freezes.
//   A pending-redirect flag squashes a wrong-path fetch that completes
//   after a taken branch.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   id_rs1/id_rs2        - source register indices of the D instruction
//   id_use_rs1/rs2       - D instruction actually reads rs1/rs2
//   ex_rd                - destination register of the E instruction
//   ex_is_load           - E instruction is a load
//   ex_branch_taken      - E resolved a taken branch/jump (PC redirect)
//   ex_mdu_start         - first cycle of a MUL/DIV op in E
//   mdu_done             - MDU result valid (level, held until E advances)
//   imem_wait/dmem_wait  - instruction/data memory access not complete
//   stall_fd             - hold PC and D register
//   flush_d              - load zero into D register (wins over stall_fd)
//   stall_e              - hold E register
//   flush_e              - load bubble into E register
//   flush_m              - load bubble into M register
//   stall_mw             - hold M and W registers
//   state_o              - FSM state for debug (0 RUN, 1 MDU_WAIT, 2 MEM_WAIT)
//   perf_stall_cnt       - cycles with stall_fd=1 (HAZ_PERF_CNT_EN only)
//   perf_flush_cnt       - cycles with flush_d=1  (HAZ_PERF_CNT_EN only)
//
// Configuration macro:
//   HAZ_PERF_CNT_EN - when defined, adds the two 32-bit performance counters.

module hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             stall_fd,
  output logic             flush_d,
  output logic             stall_e,
  output logic             flush_e,
  output logic             flush_m,
  output logic             stall_mw,
  output logic [1:0]       state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    UNUSED   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   resume_q, resume_d;   // 1: return to MDU_WAIT after a freeze
  logic   pend_q, pend_d;       // a redirect is waiting for the fetch to land

  logic freeze;
  logic load_use;
  logic eff_mdu;                // state being evaluated is MDU_WAIT

  always_comb begin
    freeze   = imem_wait | dmem_wait;
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    // While frozen, the saved state is the one that governs once the wait
    // drops; the encoding 3 behaves as RUN.
    case (state_q)
      MDU_WAIT: eff_mdu = 1'b1;
      MEM_WAIT: eff_mdu = resume_q;
      default:  eff_mdu = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    pend_d   = pend_q;
    stall_fd = 1'b0;
    flush_d  = 1'b0;
    stall_e  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    stall_mw = 1'b0;

    if (freeze) begin
      // Memory freeze overrides everything: hold the whole pipe, no flushes.
      stall_fd = 1'b1;
      stall_e  = 1'b1;
      stall_mw = 1'b1;
      state_d  = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        resume_d = eff_mdu;
      end
      // A branch resolved while a fetch is outstanding: that fetch is
      // wrong-path and must be squashed when it finally completes.
      if (!eff_mdu && ex_branch_taken && imem_wait) begin
        pend_d = 1'b1;
      end
    end else begin
      if (pend_q) begin
        flush_d = 1'b1;
        pend_d  = 1'b0;
      end

      if (eff_mdu) begin
        // E holds the MDU op; branch and load-use inputs are not meaningful.
        if (!mdu_done) begin
          stall_fd = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          state_d  = MDU_WAIT;
        end else begin
          state_d  = RUN;
        end
      end else begin
        state_d = RUN;
        if (ex_branch_taken) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          // flush_d from a pending redirect may also be set here; the D
          // register gives flush priority while the PC stays stalled.
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end else if (ex_mdu_start && !mdu_done) begin
          stall_fd = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          state_d  = MDU_WAIT;
        end
      end
    end

    if (rst) begin
      stall_fd = 1'b0;
      flush_d  = 1'b0;
      stall_e  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      stall_mw = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      resume_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      pend_q   <= pend_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_fd) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_d) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
